// File: rtl/mem_arbiter_m1.sv
// Two-port (fetch/data) arbiter in front of a single-port synchronous memory.
// Data has priority; fetch is forced through after STARVE_MAX consecutive losses.
module mem_arbiter_m1 #(
  parameter int unsigned STARVE_MAX   = 4,
  parameter bit          IF_BYTE_SWAP = 1'b1
) (
  input  logic        clk,
  input  logic        async_rst_n,
  input  logic        clk_en,
  input  logic        if_req,
  input  logic [14:0] if_addr,
  output logic        if_grant,
  output logic        if_valid,
  output logic [15:0] if_data,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [14:0] d_addr,
  input  logic [15:0] d_wdata,
  input  logic [1:0]  d_mask,
  output logic        d_grant,
  output logic        d_valid,
  output logic [15:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_wmask,
  input  logic [15:0] mem_rdata
);

  localparam logic [1:0] OP_NONE  = 2'd0;
  localparam logic [1:0] OP_IF_RD = 2'd1;
  localparam logic [1:0] OP_D_RD  = 2'd2;
  localparam logic [1:0] OP_D_WR  = 2'd3;

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  logic [1:0]  last_op_q, last_op_d;
  logic [2:0]  starve_cnt_q, starve_cnt_d;
  logic [15:0] if_hold_q, d_hold_q;
  logic [15:0] if_rdata_fmt;
  logic        issue_ok;
  logic        fetch_forced;
  logic        resp_d_rd;

  // Reset gates issue combinationally so no grant or command escapes while held in reset.
  assign issue_ok     = clk_en & async_rst_n;
  assign fetch_forced = (starve_cnt_q == STARVE_LIM);
  assign if_rdata_fmt = IF_BYTE_SWAP ? {mem_rdata[7:0], mem_rdata[15:8]} : mem_rdata;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    if_grant     = 1'b0;
    d_grant      = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_wmask    = '0;
    last_op_d    = OP_NONE;
    starve_cnt_d = starve_cnt_q;

    if (issue_ok) begin
      if (if_req && (!d_req || fetch_forced)) begin
        if_grant = 1'b1;
      end else if (d_req) begin
        d_grant = 1'b1;
      end
    end

    if (d_grant) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      last_op_d = d_we ? OP_D_WR : OP_D_RD;
      if (d_we) begin
        mem_wdata = d_wdata;
        mem_wmask = d_mask;
      end
    end else if (if_grant) begin
      mem_en    = 1'b1;
      mem_addr  = if_addr;
      last_op_d = OP_IF_RD;
    end

    if (if_grant) begin
      starve_cnt_d = '0;
    end else if (if_req && d_grant && (starve_cnt_q < STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + 3'd1;
    end
  end

  // A response is only consumed on a clk_en cycle; during a stall it stays pending
  // and the memory holds mem_rdata, so the live read data is forwarded when it completes.
  assign if_valid  = clk_en & (last_op_q == OP_IF_RD);
  assign resp_d_rd = clk_en & (last_op_q == OP_D_RD);
  assign d_valid   = resp_d_rd | (clk_en & (last_op_q == OP_D_WR));
  assign if_data   = if_valid  ? if_rdata_fmt : if_hold_q;
  assign d_rdata   = resp_d_rd ? mem_rdata    : d_hold_q;

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      last_op_q    <= OP_NONE;
      starve_cnt_q <= '0;
      if_hold_q    <= '0;
      d_hold_q     <= '0;
    end else if (clk_en) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      last_op_q    <= last_op_d;
      starve_cnt_q <= starve_cnt_d;
      if (if_valid)  if_hold_q <= if_rdata_fmt;
      if (resp_d_rd) d_hold_q  <= mem_rdata;
    end
  end

endmodule
